// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg: shared constants and helpers for the pin input conditioner.
package input_conditioner_pkg;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int CLOCK_HZ = 50_000_000;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles);
    endfunction
endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// debounce_bit: 2-flop synchroniser plus hold-time debounce counter with registered edge pulses.
module debounce_bit
    import input_conditioner_pkg::*;
#(
    parameter int CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset_signal,
    input  logic reset_value,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);
    localparam int W = cnt_width(CYCLES);
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic sync1_q, sync2_q, stable_q, stable_d, rise_q, rise_d, fall_q, fall_d, accept;
    logic [W-1:0] cnt_q, cnt_d;

    // Any sample agreeing with the stable value restarts the hold timer.
    always_comb begin
        accept   = (sync2_q != stable_q) && (cnt_q == LAST);
        cnt_d    = (sync2_q == stable_q || accept) ? '0 : cnt_q + 1'b1;
        stable_d = accept ? sync2_q : stable_q;
        rise_d   = accept && sync2_q;
        fall_d   = accept && !sync2_q;
    end

    always_ff @(posedge clock) begin
        if (reset_signal) begin
            sync1_q  <= reset_value;
            sync2_q  <= reset_value;
            stable_q <= reset_value;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign stable = stable_q;
    assign rise   = rise_q;
    assign fall   = fall_q;
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: debounced buttons and conditioned switches; DEBOUNCE_SW_EN also debounces switches.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int NUM_BUTTONS     = 3,
    parameter int NUM_SWITCHES    = 8,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                    clock,
    input  logic                    reset_signal,
    input  logic [NUM_BUTTONS-1:0]  button_n_in,
    input  logic [NUM_SWITCHES-1:0] sw_in,
    output logic [NUM_BUTTONS-1:0]  button_level,
    output logic [NUM_BUTTONS-1:0]  button_press,
    output logic [NUM_BUTTONS-1:0]  button_release,
    output logic [NUM_SWITCHES-1:0] sw_out,
    output logic                    sw_changed
);
    logic [NUM_BUTTONS-1:0] stable_n;
    logic sw_changed_q, sw_changed_d;

    // Buttons are active-low, so a falling stable level is a press.
    for (genvar b = 0; b < NUM_BUTTONS; b++) begin : g_btn
        debounce_bit #(.CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .clock       (clock),
            .reset_signal(reset_signal),
            .reset_value (1'b1),
            .raw         (button_n_in[b]),
            .stable      (stable_n[b]),
            .rise        (button_release[b]),
            .fall        (button_press[b])
        );
    end

    assign button_level = ~stable_n;

`ifdef DEBOUNCE_SW_EN
    logic [NUM_SWITCHES-1:0] sw_rise, sw_fall;

    for (genvar s = 0; s < NUM_SWITCHES; s++) begin : g_sw
        debounce_bit #(.CYCLES(DEBOUNCE_CYCLES)) u_sw (
            .clock       (clock),
            .reset_signal(reset_signal),
            .reset_value (1'b0),
            .raw         (sw_in[s]),
            .stable      (sw_out[s]),
            .rise        (sw_rise[s]),
            .fall        (sw_fall[s])
        );
    end

    // Edge pulses coincide with the sw_out update, so registering them lands one edge later.
    always_comb sw_changed_d = |(sw_rise | sw_fall);
`else
    logic [NUM_SWITCHES-1:0] sw_s1_q, sw_s2_q, sw_prev_q;

    always_ff @(posedge clock) begin
        if (reset_signal) begin
            sw_s1_q   <= '0;
            sw_s2_q   <= '0;
            sw_prev_q <= '0;
        end else begin
            sw_s1_q   <= sw_in;
            sw_s2_q   <= sw_s1_q;
            sw_prev_q <= sw_s2_q;
        end
    end

    assign sw_out = sw_s2_q;
    always_comb sw_changed_d = |(sw_s2_q ^ sw_prev_q);
`endif

    always_ff @(posedge clock) begin
        if (reset_signal) sw_changed_q <= 1'b0;
        else sw_changed_q <= sw_changed_d;
    end

    assign sw_changed = sw_changed_q;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: random and directed stimulus checked by a hold-window reference model via a scoreboard.
module tb_input_conditioner;
    localparam int D = 4;
    localparam int MAXE = 4096;
    localparam logic [10:0] RV = {8'h00, 3'b111};

    logic       clock = 1'b0;
    logic       reset_signal;
    logic [2:0] button_n_in;
    logic [7:0] sw_in;
    logic [2:0] button_level, button_press, button_release;
    logic [7:0] sw_out;
    logic       sw_changed;

    input_conditioner #(.NUM_BUTTONS(3), .NUM_SWITCHES(8), .DEBOUNCE_CYCLES(D)) dut (
        .clock         (clock),
        .reset_signal  (reset_signal),
        .button_n_in   (button_n_in),
        .sw_in         (sw_in),
        .button_level  (button_level),
        .button_press  (button_press),
        .button_release(button_release),
        .sw_out        (sw_out),
        .sw_changed    (sw_changed)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] lvl;
        logic [2:0] pr;
        logic [2:0] rl;
        logic [7:0] sw;
        logic       ch;
    } exp_t;

    exp_t exp_q[$];
    int compared = 0;
    int mismatched = 0;

    // Raw pins as the logic effectively saw them at each edge (reset forces the idle value).
    logic [10:0] rs[0:MAXE-1];
    bit          rst_at[0:MAXE-1];
    logic [7:0]  swo[0:MAXE-1];

    // Synchronised value visible just after edge e: the raw sample from one edge earlier.
    function automatic logic [10:0] sync_after(int e);
        if (e < 1 || rst_at[e]) return RV;
        return rs[e-1];
    endfunction

    // Reference: a bit takes a new value once its synchronised input has disagreed for D straight edges.
    initial begin
        logic [10:0] st, nst, v;
        exp_t x;
        bit seen_rst;
        bit acc;
        int n;
        seen_rst = 0;
        n = 0;
        st = RV;
        forever begin
            @(posedge clock);
            rst_at[n] = reset_signal;
            rs[n] = reset_signal ? RV : {sw_in, button_n_in};
            x.pr = '0;
            x.rl = '0;
            if (reset_signal) begin
                seen_rst = 1;
                st = RV;
            end else begin
                nst = st;
                for (int b = 0; b < 11; b++) begin
                    acc = 1;
                    for (int k = 0; k < D; k++) begin
                        v = sync_after(n - k - 1);
                        if (n - k < 1 || rst_at[n-k] || v[b] == st[b]) acc = 0;
                    end
                    if (acc) begin
                        nst[b] = ~st[b];
                        if (b < 3 && st[b]) x.pr[b] = 1'b1;
                        if (b < 3 && !st[b]) x.rl[b] = 1'b1;
                    end
                end
                st = nst;
            end
`ifdef DEBOUNCE_SW_EN
            swo[n] = st[10:3];
`else
            v = sync_after(n);
            swo[n] = v[10:3];
`endif
            x.lvl = ~st[2:0];
            x.sw = swo[n];
            x.ch = (n >= 2) && !reset_signal && !rst_at[n-1] && (swo[n-1] != swo[n-2]);
            if (seen_rst) exp_q.push_back(x);
            n++;
        end
    end

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, want);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("button_level", {5'b0, button_level}, {5'b0, e.lvl});
                chk("button_press", {5'b0, button_press}, {5'b0, e.pr});
                chk("button_release", {5'b0, button_release}, {5'b0, e.rl});
                chk("sw_out", sw_out, e.sw);
                chk("sw_changed", {7'b0, sw_changed}, {7'b0, e.ch});
            end
        end
    end

    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge clock);
            #2;
        end
    endtask

    initial begin
        reset_signal = 1'b1;
        button_n_in = 3'b111;
        sw_in = 8'hA5;
        cyc(3);
        reset_signal = 1'b0;
        cyc(3);
        button_n_in[2] = 1'b0;
        cyc(10);
        button_n_in[2] = 1'b1;
        cyc(10);
        for (int i = 0; i < 10; i++) begin
            button_n_in[0] = ~button_n_in[0];
            cyc(2);
        end
        button_n_in[0] = 1'b0;
        cyc(10);
        button_n_in[0] = 1'b1;
        cyc(10);
        button_n_in[1:0] = 2'b00;
        cyc(10);
        button_n_in[1:0] = 2'b11;
        cyc(10);
        sw_in = 8'h00;
        cyc(10);
        sw_in = 8'h3C;
        cyc(10);
        button_n_in[0] = 1'b0;
        cyc(4);
        reset_signal = 1'b1;
        cyc(2);
        reset_signal = 1'b0;
        cyc(12);
        button_n_in[0] = 1'b1;
        cyc(10);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                int b;
                b = $urandom_range(0, 10);
                if (b < 3) button_n_in[b] = ~button_n_in[b];
                else sw_in[b-3] = ~sw_in[b-3];
            end
            reset_signal = ($urandom_range(0, 299) == 0);
            cyc(1);
        end
        reset_signal = 1'b0;
        cyc(12);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
